// File: rtl/tpg_multimode_if.sv
// tpg_multimode_if: framebuffer write port bundle (address/colour/valid out, ready back)
interface tpg_multimode_if #(
  parameter int ADDR_WIDTH  = 17,
  parameter int COLOR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0]  fbuf_address;
  logic [COLOR_WIDTH-1:0] fbuf_color;
  logic                   fbuf_wr_en;
  logic                   fbuf_ready;
  modport master (output fbuf_address, fbuf_color, fbuf_wr_en, input fbuf_ready);
  modport slave  (input fbuf_address, fbuf_color, fbuf_wr_en, output fbuf_ready);
endinterface

// File: rtl/tpg_multimode.sv
// tpg_multimode: multi-mode test pattern generator writing one scaled frame into a framebuffer
// Optional TPG_SCROLL_EN: pattern x coordinate scrolls right by one pixel per completed frame
module tpg_multimode #(
  parameter int FRAME_WIDTH    = 1920,
  parameter int FRAME_HEIGHT   = 1080,
  parameter int SCALING_FACTOR = 4,
  parameter int ADDR_WIDTH     = 17,
  parameter int COLOR_WIDTH    = 12,
  parameter int GRID_LOG2      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   continuous,
  input  logic [2:0]             mode,
  input  logic [COLOR_WIDTH-1:0] fg_color,
  input  logic [COLOR_WIDTH-1:0] bg_color,
  tpg_multimode_if.master        fbuf,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            frame_count
);
  localparam int W  = FRAME_WIDTH / SCALING_FACTOR;
  localparam int H  = FRAME_HEIGHT / SCALING_FACTOR;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int C  = COLOR_WIDTH / 3;
  localparam logic [XW:0]          W_EXT = (XW+1)'(W);
  localparam logic [GRID_LOG2-1:0] MID   = GRID_LOG2'(1 << (GRID_LOG2 - 1));

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  // bar = floor(px*8/W) and ramp = floor(px*2^C/W), tracked with remainders instead of dividers
  typedef struct packed {
    logic [XW-1:0] px;
    logic [2:0]    bar;
    logic [XW-1:0] bar_acc;
    logic [C-1:0]  ramp;
    logic [XW-1:0] ramp_acc;
  } pat_t;

  function automatic pat_t step(pat_t p);
    pat_t s;
    logic [XW:0] tbar, tramp;
    tbar       = {1'b0, p.bar_acc} + (XW+1)'(8);
    tramp      = {1'b0, p.ramp_acc} + (XW+1)'(2 ** C);
    s.px       = p.px + 1'b1;
    s.bar      = p.bar + 3'(tbar >= W_EXT);
    s.bar_acc  = XW'(tbar >= W_EXT ? tbar - W_EXT : tbar);
    s.ramp     = p.ramp + C'(tramp >= W_EXT);
    s.ramp_acc = XW'(tramp >= W_EXT ? tramp - W_EXT : tramp);
    return p.px == XW'(W - 1) ? '0 : s;
  endfunction

  state_t                 state, state_n;
  pat_t                   pat, pat_n, org_n;
  logic [XW-1:0]          x, x_n;
  logic [YW-1:0]          y, y_n;
  logic [GRID_LOG2:0]     yg;
  logic [2:0]             mode_q, m_n;
  logic [COLOR_WIDTH-1:0] fg_q, bg_q, fg_n, bg_n, bars, ramp, pix, color_n;
  logic [ADDR_WIDTH-1:0]  addr_n;
  logic                   load, acc, x_end, last, grid, chk;

`ifdef TPG_SCROLL_EN
  pat_t org;
  assign org_n = state == DONE ? step(org) : org;
  always_ff @(posedge clk or posedge rst)
    if (rst) org <= '0;
    else     org <= org_n;
`else
  assign org_n = '0;
`endif

  assign fbuf.fbuf_wr_en = state == RUN;
  assign busy            = state != IDLE;
  assign frame_done      = state == DONE;

  always_comb begin
    load    = (state == IDLE && start) || (state == DONE && continuous);
    acc     = state == RUN && fbuf.fbuf_ready;
    x_end   = x == XW'(W - 1);
    last    = x_end && y == YW'(H - 1);
    m_n     = load ? mode : mode_q;
    fg_n    = load ? fg_color : fg_q;
    bg_n    = load ? bg_color : bg_q;
    x_n     = load || (acc && x_end) ? '0 : acc ? x + 1'b1 : x;
    y_n     = load || (acc && last) ? '0 : acc && x_end ? y + 1'b1 : y;
    pat_n   = load || (acc && x_end) ? org_n : acc ? step(pat) : pat;
    yg      = (GRID_LOG2+1)'(y_n);
    grid    = pat_n.px[GRID_LOG2-1:0] == MID || yg[GRID_LOG2-1:0] == MID;
    chk     = pat_n.px[GRID_LOG2] ^ yg[GRID_LOG2];
    bars    = {{C{~pat_n.bar[1]}}, {C{~pat_n.bar[2]}}, {C{~pat_n.bar[0]}}};
    ramp    = {3{pat_n.ramp}};
    pix     = m_n == 3'd0 ? (grid ? fg_n : bg_n) :
              m_n == 3'd1 ? fg_n :
              m_n == 3'd2 ? bars :
              m_n == 3'd3 ? (chk ? fg_n : bg_n) :
              m_n == 3'd4 ? ramp : bg_n;
    color_n = load || acc ? pix : fbuf.fbuf_color;
    addr_n  = load ? '0 : acc && !last ? fbuf.fbuf_address + 1'b1 : fbuf.fbuf_address;
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (acc && last ? DONE : RUN) :
              (continuous ? RUN : IDLE);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state             <= IDLE;
      x                 <= '0;
      y                 <= '0;
      pat               <= '0;
      mode_q            <= '0;
      fg_q              <= '0;
      bg_q              <= '0;
      fbuf.fbuf_address <= '0;
      fbuf.fbuf_color   <= '0;
      frame_count       <= '0;
    end else begin
      state             <= state_n;
      x                 <= x_n;
      y                 <= y_n;
      pat               <= pat_n;
      mode_q            <= m_n;
      fg_q              <= fg_n;
      bg_q              <= bg_n;
      fbuf.fbuf_address <= addr_n;
      fbuf.fbuf_color   <= color_n;
      frame_count       <= frame_count + 16'(acc && last);
    end
endmodule

// File: tb/tb_tpg_multimode.sv
// tb_tpg_multimode: directed bench for tpg_multimode on a 480x18 scaled frame
module tb_tpg_multimode;
  localparam int FW = 1920, FH = 72, SF = 4, AW = 17, CW = 12, GL = 5;
  localparam int W = FW / SF, H = FH / SF, N = W * H;
`ifdef TPG_SCROLL_EN
  localparam int SCR = 1;
`else
  localparam int SCR = 0;
`endif

  logic          clk = 0, rst = 1, start = 0, continuous = 0;
  logic [2:0]    mode = 0;
  logic [CW-1:0] fg = 0, bg = 0;
  logic          busy, frame_done;
  logic [15:0]   frame_count;
  int            total = 0, bad = 0;

  tpg_multimode_if #(.ADDR_WIDTH(AW), .COLOR_WIDTH(CW)) fb ();

  tpg_multimode #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .SCALING_FACTOR(SF),
    .ADDR_WIDTH(AW), .COLOR_WIDTH(CW), .GRID_LOG2(GL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .mode(mode),
    .fg_color(fg), .bg_color(bg), .fbuf(fb), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [CW-1:0] model(int m, logic [CW-1:0] f, logic [CW-1:0] b, int x, int y, int off);
    logic [CW-1:0] tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    logic [3:0] r;
    int px;
    px = (x + off) % W;
    r  = 4'(px * 16 / W);
    case (m)
      0: return ((px % (1 << GL)) == (1 << (GL - 1)) || (y % (1 << GL)) == (1 << (GL - 1))) ? f : b;
      1: return f;
      2: return tab[px * 8 / W];
      3: return (((px >> GL) ^ (y >> GL)) & 1) != 0 ? f : b;
      4: return {r, r, r};
      default: return b;
    endcase
  endfunction

  task tick;
    @(posedge clk);
    #1;
  endtask

  task pulse_start;
    start = 1;
    tick();
    start = 0;
  endtask

  task hard_reset;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    start = 0;
    tick();
  endtask

  task test_reset;
    repeat (2) tick();
    total++;
    if ({fb.fbuf_wr_en, busy, frame_done, fb.fbuf_address, fb.fbuf_color, frame_count} !== '0) begin
      bad++;
      $display("FAIL reset_state: en=%b busy=%b done=%b addr=%0d col=%h cnt=%0d, want all 0",
               fb.fbuf_wr_en, busy, frame_done, fb.fbuf_address, fb.fbuf_color, frame_count);
    end
    @(negedge clk);
    rst = 0;
    mode = 1; fg = 12'hABC; bg = 12'h123; fb.fbuf_ready = 1;
    tick();
    pulse_start();
    repeat (20) tick();
    total++;
    if (fb.fbuf_address !== AW'(20) || fb.fbuf_color !== 12'hABC) begin
      bad++;
      $display("FAIL pre_reset_run: addr=%0d col=%h want addr=20 col=abc", fb.fbuf_address, fb.fbuf_color);
    end
    @(negedge clk);
    #2 rst = 1;
    #1;
    total++;
    if ({fb.fbuf_wr_en, busy, frame_done, fb.fbuf_address, fb.fbuf_color, frame_count} !== '0) begin
      bad++;
      $display("FAIL async_reset: en=%b busy=%b addr=%0d col=%h cnt=%0d, want all 0",
               fb.fbuf_wr_en, busy, fb.fbuf_address, fb.fbuf_color, frame_count);
    end
    @(negedge clk);
    rst = 0;
    tick();
    pulse_start();
    total++;
    if (fb.fbuf_wr_en !== 1'b1 || fb.fbuf_address !== '0 || fb.fbuf_color !== 12'hABC) begin
      bad++;
      $display("FAIL first_write: en=%b addr=%0d col=%h want en=1 addr=0 col=abc",
               fb.fbuf_wr_en, fb.fbuf_address, fb.fbuf_color);
    end
  endtask

  task test_grid;
    bit err;
    logic [CW-1:0] want;
    hard_reset();
    mode = 0; fg = 12'hF00; bg = 12'h00F; continuous = 0; fb.fbuf_ready = 1;
    pulse_start();
    err = 0;
    for (int e = 0; e < N && !err; e++) begin
      want = model(0, 12'hF00, 12'h00F, e % W, e / W, 0);
      total++;
      if (fb.fbuf_wr_en !== 1'b1 || fb.fbuf_address !== AW'(e) || fb.fbuf_color !== want) begin
        bad++; err = 1;
        $display("FAIL grid_pixel: en=%b addr=%0d col=%h want en=1 addr=%0d col=%h",
                 fb.fbuf_wr_en, fb.fbuf_address, fb.fbuf_color, e, want);
      end
      if (e == 0 || e == 16 || e == 7680) begin
        want = e == 0 ? 12'h00F : 12'hF00;
        total++;
        if (fb.fbuf_color !== want) begin
          bad++;
          $display("FAIL grid_spot: addr=%0d col=%h want %h", e, fb.fbuf_color, want);
        end
      end
      tick();
    end
    total++;
    if ({frame_done, fb.fbuf_wr_en, busy} !== 3'b101 || frame_count !== 16'd1) begin
      bad++;
      $display("FAIL grid_done: done=%b en=%b busy=%b cnt=%0d want done=1 en=0 busy=1 cnt=1",
               frame_done, fb.fbuf_wr_en, busy, frame_count);
    end
    tick();
    total++;
    if ({frame_done, fb.fbuf_wr_en, busy} !== 3'b000 || frame_count !== 16'd1) begin
      bad++;
      $display("FAIL grid_idle: done=%b en=%b busy=%b cnt=%0d want 0 0 0 cnt=1",
               frame_done, fb.fbuf_wr_en, busy, frame_count);
    end
  endtask

  task test_checker_stall;
    int e, cyc;
    bit err, stalled;
    logic [AW-1:0] pa;
    logic [CW-1:0] pc, want;
    hard_reset();
    mode = 3; fg = 12'h0F0; bg = 12'hF0F; fb.fbuf_ready = 0;
    pulse_start();
    e = 0; cyc = 0; err = 0; stalled = 0;
    while (e < N && cyc < 8 * N && !err) begin
      want = model(3, 12'h0F0, 12'hF0F, e % W, e / W, 0);
      total++;
      if (fb.fbuf_wr_en !== 1'b1 || fb.fbuf_address !== AW'(e) || fb.fbuf_color !== want) begin
        bad++; err = 1;
        $display("FAIL checker_pixel: en=%b addr=%0d col=%h want en=1 addr=%0d col=%h",
                 fb.fbuf_wr_en, fb.fbuf_address, fb.fbuf_color, e, want);
      end
      if (stalled) begin
        total++;
        if (fb.fbuf_address !== pa || fb.fbuf_color !== pc) begin
          bad++; err = 1;
          $display("FAIL stall_hold: addr=%0d col=%h want addr=%0d col=%h", fb.fbuf_address, fb.fbuf_color, pa, pc);
        end
      end
      fb.fbuf_ready = 1'($urandom_range(0, 1));
      stalled = !fb.fbuf_ready;
      pa = fb.fbuf_address;
      pc = fb.fbuf_color;
      if (fb.fbuf_ready) e++;
      tick();
      cyc++;
    end
    fb.fbuf_ready = 1;
    total++;
    if (e != N) begin
      bad++;
      $display("FAIL checker_count: accepted=%0d want %0d", e, N);
    end
    total++;
    if (frame_done !== 1'b1 || frame_count !== 16'd1) begin
      bad++;
      $display("FAIL checker_done: done=%b cnt=%0d want done=1 cnt=1", frame_done, frame_count);
    end
  endtask

  task test_bars_ramp;
    int xs [6] = '{0, 59, 60, 419, 420, 479};
    logic [CW-1:0] cs [6] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'h00F, 12'h000, 12'h000};
    logic [CW-1:0] want;
    hard_reset();
    mode = 2; fb.fbuf_ready = 1;
    pulse_start();
    for (int x = 0; x < W; x++) begin
      want = model(2, 0, 0, x, 0, 0);
      total++;
      if (fb.fbuf_address !== AW'(x) || fb.fbuf_color !== want) begin
        bad++;
        $display("FAIL bars_pixel: addr=%0d col=%h want addr=%0d col=%h", fb.fbuf_address, fb.fbuf_color, x, want);
      end
      for (int k = 0; k < 6; k++)
        if (x == xs[k]) begin
          total++;
          if (fb.fbuf_color !== cs[k]) begin
            bad++;
            $display("FAIL bars_spot: x=%0d col=%h want %h", x, fb.fbuf_color, cs[k]);
          end
        end
      tick();
    end
    hard_reset();
    mode = 4;
    pulse_start();
    for (int x = 0; x < W; x++) begin
      want = x == 0 ? 12'h000 : x == W - 1 ? 12'hFFF : model(4, 0, 0, x, 0, 0);
      total++;
      if (fb.fbuf_color !== want) begin
        bad++;
        $display("FAIL ramp_pixel: x=%0d col=%h want %h", x, fb.fbuf_color, want);
      end
      tick();
    end
  endtask

  task test_continuous;
    bit err;
    logic [CW-1:0] want;
    hard_reset();
    mode = 0; fg = 12'hF00; bg = 12'h00F; continuous = 1; fb.fbuf_ready = 1;
    pulse_start();
    err = 0;
    for (int e = 0; e < N && !err; e++) begin
      if (e == 100) begin mode = 1; fg = 12'h0F0; end
      want = model(0, 12'hF00, 12'h00F, e % W, e / W, 0);
      total++;
      if (fb.fbuf_wr_en !== 1'b1 || fb.fbuf_address !== AW'(e) || fb.fbuf_color !== want) begin
        bad++; err = 1;
        $display("FAIL cont_f0: en=%b addr=%0d col=%h want en=1 addr=%0d col=%h",
                 fb.fbuf_wr_en, fb.fbuf_address, fb.fbuf_color, e, want);
      end
      tick();
    end
    total++;
    if (fb.fbuf_wr_en !== 1'b0 || frame_done !== 1'b1) begin
      bad++;
      $display("FAIL cont_gap: en=%b done=%b want en=0 done=1", fb.fbuf_wr_en, frame_done);
    end
    tick();
    continuous = 0;
    err = 0;
    for (int e = 0; e < N && !err; e++) begin
      total++;
      if (fb.fbuf_wr_en !== 1'b1 || fb.fbuf_address !== AW'(e) || fb.fbuf_color !== 12'h0F0) begin
        bad++; err = 1;
        $display("FAIL cont_f1: en=%b addr=%0d col=%h want en=1 addr=%0d col=0f0",
                 fb.fbuf_wr_en, fb.fbuf_address, fb.fbuf_color, e);
      end
      tick();
    end
    total++;
    if (frame_done !== 1'b1 || frame_count !== 16'd2) begin
      bad++;
      $display("FAIL cont_done2: done=%b cnt=%0d want done=1 cnt=2", frame_done, frame_count);
    end
    tick();
    total++;
    if (busy !== 1'b0 || fb.fbuf_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL cont_stop: busy=%b en=%b want 0 0", busy, fb.fbuf_wr_en);
    end
  endtask

  task test_reset_midframe;
    bit err, seen;
    logic [CW-1:0] want;
    hard_reset();
    mode = 0; fg = 12'hFFF; bg = 12'h000; continuous = 1; fb.fbuf_ready = 1;
    pulse_start();
    err = 0;
    for (int e = 0; e < N && !err; e++) begin
      want = model(0, 12'hFFF, 12'h000, e % W, e / W, 0);
      total++;
      if (fb.fbuf_color !== want) begin
        bad++; err = 1;
        $display("FAIL mid_f0: addr=%0d col=%h want %h", e, fb.fbuf_color, want);
      end
      tick();
    end
    tick();
    err = 0;
    for (int e = 0; e < 1000 && !err; e++) begin
      want = model(0, 12'hFFF, 12'h000, e % W, e / W, SCR);
      total++;
      if (fb.fbuf_address !== AW'(e) || fb.fbuf_color !== want) begin
        bad++; err = 1;
        $display("FAIL mid_f1: addr=%0d col=%h want addr=%0d col=%h", fb.fbuf_address, fb.fbuf_color, e, want);
      end
      tick();
    end
    @(negedge clk);
    #2 rst = 1;
    #1;
    total++;
    if ({fb.fbuf_wr_en, busy, frame_done, fb.fbuf_address, fb.fbuf_color, frame_count} !== '0) begin
      bad++;
      $display("FAIL mid_reset: en=%b busy=%b addr=%0d col=%h cnt=%0d want all 0",
               fb.fbuf_wr_en, busy, fb.fbuf_address, fb.fbuf_color, frame_count);
    end
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (50) begin
      tick();
      if (fb.fbuf_wr_en !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL mid_quiet: write or busy seen after reset, want none");
    end
    continuous = 0;
  endtask

  initial begin
    fb.fbuf_ready = 0;
    test_reset();
    test_grid();
    test_checker_stall();
    test_bars_ramp();
    test_continuous();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
